// File: rtl/ber_checker.sv
// PRBS9 bit-error-rate checker for one QPSK branch: searches the receive latency
// that aligns a local reference with the sliced bits, then accumulates bit/error counts.
module ber_checker #(
    parameter logic [8:0] PRBS_SEED          = 9'h1AA,
    parameter int         MAX_LAT            = 511,
    parameter int         SYNC_LEN           = 511,
    parameter int         SYNC_ERR_MAX       = 0,
    parameter int         LOSS_ERR_MAX       = 64,
    parameter int         ERR_OK_MAX         = 0,
    parameter int         NBT_COUNT_BITS_ERR = 64
) (
    input  logic                          clk,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic                          i_valid,
    input  logic                          i_rx_bit,
    output logic [NBT_COUNT_BITS_ERR-1:0] o_accum_err,
    output logic [NBT_COUNT_BITS_ERR-1:0] o_accum_tot,
    output logic [8:0]                    o_latency,
    output logic                          o_sync_done,
    output logic                          o_ber_ok,
    output logic [1:0]                    o_state
);

    localparam int WW = $clog2(SYNC_LEN + 1);
    localparam int NB = NBT_COUNT_BITS_ERR;

    typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, LOCKED = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [8:0]         prbs_q, prbs_d;
    logic [MAX_LAT-1:0] dl_q, dl_d;
    logic [8:0]         lat_q, lat_d;
    logic [WW-1:0]      win_cnt_q, win_cnt_d;
    logic [WW-1:0]      win_err_q, win_err_d;
    logic [NB-1:0]      err_q, err_d;
    logic [NB-1:0]      tot_q, tot_d;
    logic               ber_ok_q, ber_ok_d;

    logic          new_bit;
    logic          tap;
    logic          mismatch;
    logic [WW-1:0] win_err_inc;
    logic          win_end;

    // dl_q[k] holds the reference from k+1 strobes ago; latency 0 uses this strobe's bit.
    assign new_bit     = prbs_q[8] ^ prbs_q[4];
    assign tap         = (lat_q == 9'd0) ? new_bit : dl_q[lat_q - 9'd1];
    assign mismatch    = i_rx_bit ^ tap;
    assign win_err_inc = win_err_q + WW'(mismatch);
    assign win_end     = (win_cnt_q == WW'(SYNC_LEN - 1));

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            prbs_q    <= PRBS_SEED;
            dl_q      <= '0;
            lat_q     <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            err_q     <= '0;
            tot_q     <= '0;
            ber_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prbs_q    <= prbs_d;
            dl_q      <= dl_d;
            lat_q     <= lat_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            err_q     <= err_d;
            tot_q     <= tot_d;
            ber_ok_q  <= ber_ok_d;
        end
    end

    // i_valid is a one-cycle strobe with no back-pressure: each high cycle carries one
    // bit; only disable and the IDLE->SEARCH start act on edges without a strobe.
    always_comb begin
        state_d   = state_q;
        prbs_d    = prbs_q;
        dl_d      = dl_q;
        lat_d     = lat_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        err_d     = err_q;
        tot_d     = tot_q;
        if (!i_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = SEARCH;
                    lat_d     = '0;
                    win_cnt_d = '0;
                    win_err_d = '0;
                end
                SEARCH, LOCKED: begin
                    if (i_valid) begin
                        prbs_d = {prbs_q[7:0], new_bit};
                        dl_d   = {dl_q[MAX_LAT-2:0], new_bit};
                        if (win_end) begin
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end else begin
                            win_cnt_d = win_cnt_q + WW'(1);
                            win_err_d = win_err_inc;
                        end
                        if (state_q == SEARCH) begin
                            if (win_end) begin
                                if (int'(win_err_inc) <= SYNC_ERR_MAX) begin
                                    state_d = LOCKED;
                                    tot_d   = '0;
                                    err_d   = '0;
                                end else begin
                                    lat_d = (lat_q == 9'(MAX_LAT)) ? 9'd0 : lat_q + 9'd1;
                                end
                            end
                        end else begin
                            // Saturating accumulators: tot and err stick at all-ones independently.
                            if (tot_q != '1) tot_d = tot_q + NB'(1);
                            if (mismatch && (err_q != '1)) err_d = err_q + NB'(1);
                            if (win_end && (int'(win_err_inc) > LOSS_ERR_MAX)) begin
                                state_d = SEARCH;
                                lat_d   = '0;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        ber_ok_d = (state_d == LOCKED) && (err_d <= NB'(ERR_OK_MAX));
    end

    assign o_accum_err = err_q;
    assign o_accum_tot = tot_q;
    assign o_latency   = lat_q;
    assign o_sync_done = (state_q == LOCKED);
    assign o_ber_ok    = ber_ok_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_ber_checker.sv
// Bench for ber_checker: a full-size instance for lock/count/loss/enable/reset behaviour and
// a short-window narrow-counter instance for latency extremes and saturation.
module tb_ber_checker;

    localparam int W    = 129;
    localparam int SL   = 511;
    localparam int SL_B = 31;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_reset, a_enable, a_valid, a_rx;
    logic [63:0] a_err, a_tot;
    logic [8:0]  a_lat;
    logic        a_sync, a_ok;
    logic [1:0]  a_state;

    logic        b_reset, b_enable, b_valid, b_rx;
    logic [3:0]  b_err, b_tot;
    logic [8:0]  b_lat;
    logic        b_sync, b_ok;
    logic [1:0]  b_state;

    ber_checker dut_a (
        .clk(clk), .i_reset(a_reset), .i_enable(a_enable), .i_valid(a_valid), .i_rx_bit(a_rx),
        .o_accum_err(a_err), .o_accum_tot(a_tot), .o_latency(a_lat),
        .o_sync_done(a_sync), .o_ber_ok(a_ok), .o_state(a_state)
    );

    ber_checker #(.SYNC_LEN(SL_B), .NBT_COUNT_BITS_ERR(4)) dut_b (
        .clk(clk), .i_reset(b_reset), .i_enable(b_enable), .i_valid(b_valid), .i_rx_bit(b_rx),
        .o_accum_err(b_err), .o_accum_tot(b_tot), .o_latency(b_lat),
        .o_sync_done(b_sync), .o_ber_ok(b_ok), .o_state(b_state)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0]    m_s [2];
    logic [1023:0] m_h [2];
    logic          s_rx, s_al;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp_v, got_v;

    // One bit strobe: rx is the reference delayed by 'delay', optionally random and/or inverted.
    task automatic strobe(input bit sel, input int delay, input bit rnd, input bit flip, input bit active);
        logic nb, r;
        nb   = m_s[sel][8] ^ m_s[sel][4];
        s_al = (delay == 0) ? nb : m_h[sel][10'(delay - 1)];
        r    = rnd ? 1'($urandom_range(0, 1)) : s_al;
        r    = r ^ flip;
        if (active) begin
            m_s[sel] = {m_s[sel][7:0], nb};
            m_h[sel] = {m_h[sel][1022:0], nb};
        end
        if (sel == 1'b0) begin a_valid = 1'b1; a_rx = r; end
        else begin b_valid = 1'b1; b_rx = r; end
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        s_rx    = r;
    endtask

    task automatic run(input bit sel, input int delay, input int n);
        for (int i = 0; i < n; i++) strobe(sel, delay, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic reset_dut(input bit sel);
        if (sel == 1'b0) a_reset = 1'b1; else b_reset = 1'b1;
        m_s[sel] = 9'h1AA;
        m_h[sel] = '0;
        repeat (2) @(posedge clk);
        #1;
        a_reset = 1'b0;
        b_reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        a_enable = 1'b0; b_enable = 1'b0;
        a_reset = 1'b1; b_reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (a_err !== 64'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", a_err); end
        checks++; if (a_tot !== 64'd0) begin errors++; $display("FAIL reset_tot: got %0d expected 0", a_tot); end
        checks++; if (a_lat !== 9'd0) begin errors++; $display("FAIL reset_lat: got %0d expected 0", a_lat); end
        checks++; if (a_sync !== 1'b0) begin errors++; $display("FAIL reset_sync: got %0b expected 0", a_sync); end
        checks++; if (a_ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %0b expected 0", a_ok); end
        checks++; if (b_state !== 2'd0) begin errors++; $display("FAIL reset_state_b: got %0d expected 0", b_state); end
        a_reset = 1'b0; b_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", a_state); end
    endtask

    task automatic test_lock_37();
        a_enable = 1'b1;
        reset_dut(1'b0);
        checks++; if (a_state !== 2'd1) begin errors++; $display("FAIL start_search: got %0d expected 1", a_state); end
        run(1'b0, 37, 38 * SL - 1);
        checks++; if (a_sync !== 1'b0) begin errors++; $display("FAIL lock37_early: got %0b expected 0", a_sync); end
        run(1'b0, 37, 1);
        checks++; if (a_sync !== 1'b1) begin errors++; $display("FAIL lock37_sync: got %0b expected 1", a_sync); end
        checks++; if (a_lat !== 9'd37) begin errors++; $display("FAIL lock37_lat: got %0d expected 37", a_lat); end
        for (int i = 1; i <= 1000; i++) begin
            exp_q.push_back({1'b1, 64'(i), 64'd0});
            strobe(1'b0, 37, 1'b0, 1'b0, 1'b1);
            exp_v = exp_q.pop_front();
            got_v = {a_sync, a_tot, a_err};
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL count37[%0d]: got sync=%0b tot=%0d err=%0d expected sync=%0b tot=%0d err=%0d", i, got_v[128], got_v[127:64], got_v[63:0], exp_v[128], exp_v[127:64], exp_v[63:0]); end
        end
        checks++; if (a_ok !== 1'b1) begin errors++; $display("FAIL lock37_ok: got %0b expected 1", a_ok); end
    endtask

    task automatic test_ber_count();
        int e;
        logic f;
        e = 0;
        reset_dut(1'b0);
        run(1'b0, 5, 6 * SL);
        checks++; if (a_sync !== 1'b1 || a_lat !== 9'd5) begin errors++; $display("FAIL lock5: got sync=%0b lat=%0d expected sync=1 lat=5", a_sync, a_lat); end
        for (int i = 1; i <= 10000; i++) begin
            f = (i % 100 == 0);
            e += int'(f);
            exp_q.push_back({1'b1, 64'(i), 64'(e)});
            strobe(1'b0, 5, 1'b0, f, 1'b1);
            exp_v = exp_q.pop_front();
            got_v = {a_sync, a_tot, a_err};
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL ber[%0d]: got sync=%0b tot=%0d err=%0d expected sync=%0b tot=%0d err=%0d", i, got_v[128], got_v[127:64], got_v[63:0], exp_v[128], exp_v[127:64], exp_v[63:0]); end
        end
        checks++; if (a_err !== 64'd100) begin errors++; $display("FAIL ber_err: got %0d expected 100", a_err); end
        checks++; if (a_tot !== 64'd10000) begin errors++; $display("FAIL ber_tot: got %0d expected 10000", a_tot); end
        checks++; if (a_ok !== 1'b0) begin errors++; $display("FAIL ber_ok: got %0b expected 0", a_ok); end
    endtask

    task automatic test_loss_relock();
        int n, ec;
        logic dropped;
        logic [63:0] ht, he;
        n = 0; ec = 0; dropped = 1'b0;
        while (!dropped && n < 2 * SL) begin
            strobe(1'b0, 5, 1'b1, 1'b0, 1'b1);
            n++;
            ec += int'(s_rx ^ s_al);
            if (a_sync === 1'b0) dropped = 1'b1;
        end
        checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL loss_timeout: got sync=%0b after %0d strobes expected 0", a_sync, n); end
        checks++; if (a_lat !== 9'd0 || a_state !== 2'd1) begin errors++; $display("FAIL loss_search: got lat=%0d state=%0d expected lat=0 state=1", a_lat, a_state); end
        ht = 64'(10000 + n);
        he = 64'(100 + ec);
        checks++; if (a_tot !== ht || a_err !== he) begin errors++; $display("FAIL loss_counts: got tot=%0d err=%0d expected tot=%0d err=%0d", a_tot, a_err, ht, he); end
        for (int i = 1; i < 6 * SL; i++) begin
            exp_q.push_back({1'b0, ht, he});
            strobe(1'b0, 5, 1'b0, 1'b0, 1'b1);
            exp_v = exp_q.pop_front();
            got_v = {a_sync, a_tot, a_err};
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL hold[%0d]: got sync=%0b tot=%0d err=%0d expected sync=%0b tot=%0d err=%0d", i, got_v[128], got_v[127:64], got_v[63:0], exp_v[128], exp_v[127:64], exp_v[63:0]); end
        end
        run(1'b0, 5, 1);
        checks++; if (a_sync !== 1'b1 || a_lat !== 9'd5) begin errors++; $display("FAIL relock: got sync=%0b lat=%0d expected sync=1 lat=5", a_sync, a_lat); end
        checks++; if (a_tot !== 64'd0 || a_err !== 64'd0) begin errors++; $display("FAIL relock_clear: got tot=%0d err=%0d expected 0 0", a_tot, a_err); end
    endtask

    task automatic test_enable_drop();
        run(1'b0, 5, 50);
        a_enable = 1'b0;
        @(posedge clk); #1;
        checks++; if (a_state !== 2'd0 || a_sync !== 1'b0 || a_ok !== 1'b0) begin errors++; $display("FAIL drop_locked: got state=%0d sync=%0b ok=%0b expected 0 0 0", a_state, a_sync, a_ok); end
        checks++; if (a_tot !== 64'd50 || a_err !== 64'd0) begin errors++; $display("FAIL drop_freeze: got tot=%0d err=%0d expected 50 0", a_tot, a_err); end
        for (int i = 0; i < 20; i++) strobe(1'b0, 5, 1'b0, 1'b0, 1'b0);
        checks++; if (a_tot !== 64'd50 || a_state !== 2'd0) begin errors++; $display("FAIL idle_valid: got tot=%0d state=%0d expected 50 0", a_tot, a_state); end
        a_enable = 1'b1;
        @(posedge clk); #1;
        checks++; if (a_state !== 2'd1 || a_lat !== 9'd0) begin errors++; $display("FAIL reenable1: got state=%0d lat=%0d expected 1 0", a_state, a_lat); end
        run(1'b0, 5, 700);
        checks++; if (a_lat !== 9'd1 || a_tot !== 64'd50) begin errors++; $display("FAIL mid_search: got lat=%0d tot=%0d expected 1 50", a_lat, a_tot); end
        a_enable = 1'b0;
        @(posedge clk); #1;
        checks++; if (a_state !== 2'd0 || a_sync !== 1'b0 || a_tot !== 64'd50) begin errors++; $display("FAIL drop_search: got state=%0d sync=%0b tot=%0d expected 0 0 50", a_state, a_sync, a_tot); end
        a_enable = 1'b1;
        @(posedge clk); #1;
        checks++; if (a_state !== 2'd1 || a_lat !== 9'd0) begin errors++; $display("FAIL reenable2: got state=%0d lat=%0d expected 1 0", a_state, a_lat); end
        run(1'b0, 5, 6 * SL);
        checks++; if (a_sync !== 1'b1 || a_lat !== 9'd5) begin errors++; $display("FAIL relock2: got sync=%0b lat=%0d expected 1 5", a_sync, a_lat); end
    endtask

    task automatic test_async_reset();
        run(1'b0, 5, 30);
        checks++; if (a_tot !== 64'd30) begin errors++; $display("FAIL pre_reset_tot: got %0d expected 30", a_tot); end
        @(posedge clk); #3;
        a_reset = 1'b1;
        #1;
        checks++; if (a_tot !== 64'd0 || a_err !== 64'd0 || a_lat !== 9'd0) begin errors++; $display("FAIL async_counts: got tot=%0d err=%0d lat=%0d expected 0 0 0", a_tot, a_err, a_lat); end
        checks++; if (a_sync !== 1'b0 || a_ok !== 1'b0 || a_state !== 2'd0) begin errors++; $display("FAIL async_flags: got sync=%0b ok=%0b state=%0d expected 0 0 0", a_sync, a_ok, a_state); end
        #1;
        a_reset = 1'b0;
        m_s[0] = 9'h1AA;
        m_h[0] = '0;
    endtask

    task automatic test_max_lat();
        logic early;
        early = 1'b0;
        b_enable = 1'b1;
        reset_dut(1'b1);
        for (int i = 0; i < 512 * SL_B - 1; i++) begin
            strobe(1'b1, 511, 1'b0, 1'b0, 1'b1);
            if (b_sync === 1'b1) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL maxlat_early: got early lock=%0b expected 0", early); end
        run(1'b1, 511, 1);
        checks++; if (b_sync !== 1'b1 || b_lat !== 9'd511) begin errors++; $display("FAIL maxlat_lock: got sync=%0b lat=%0d expected 1 511", b_sync, b_lat); end
    endtask

    task automatic test_lat_wrap();
        logic seen;
        seen = 1'b0;
        reset_dut(1'b1);
        for (int i = 0; i < 511 * SL_B; i++) begin
            strobe(1'b1, 512, 1'b0, 1'b0, 1'b1);
            if (b_sync === 1'b1) seen = 1'b1;
        end
        checks++; if (b_lat !== 9'd511) begin errors++; $display("FAIL wrap_at_max: got %0d expected 511", b_lat); end
        for (int i = 0; i < SL_B; i++) begin
            strobe(1'b1, 512, 1'b0, 1'b0, 1'b1);
            if (b_sync === 1'b1) seen = 1'b1;
        end
        checks++; if (b_lat !== 9'd0) begin errors++; $display("FAIL wrap_to_zero: got %0d expected 0", b_lat); end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL wrap_no_sync: got seen=%0b expected 0", seen); end
    endtask

    task automatic test_saturate();
        int e;
        logic f;
        e = 0;
        reset_dut(1'b1);
        run(1'b1, 0, SL_B);
        checks++; if (b_sync !== 1'b1 || b_lat !== 9'd0) begin errors++; $display("FAIL sat_lock: got sync=%0b lat=%0d expected 1 0", b_sync, b_lat); end
        for (int i = 1; i <= 34; i++) begin
            f = (i > 14);
            e += int'(f);
            exp_q.push_back({1'b1, 64'((i > 15) ? 15 : i), 64'((e > 15) ? 15 : e)});
            strobe(1'b1, 0, 1'b0, f, 1'b1);
            exp_v = exp_q.pop_front();
            got_v = {b_sync, 64'(b_tot), 64'(b_err)};
            checks++;
            if (got_v !== exp_v) begin errors++; $display("FAIL sat[%0d]: got sync=%0b tot=%0d err=%0d expected sync=%0b tot=%0d err=%0d", i, got_v[128], got_v[127:64], got_v[63:0], exp_v[128], exp_v[127:64], exp_v[63:0]); end
        end
        checks++; if (b_ok !== 1'b0 || b_state !== 2'd2) begin errors++; $display("FAIL sat_flags: got ok=%0b state=%0d expected 0 2", b_ok, b_state); end
    endtask

    initial begin
        a_reset = 1'b1; a_enable = 1'b0; a_valid = 1'b0; a_rx = 1'b0;
        b_reset = 1'b1; b_enable = 1'b0; b_valid = 1'b0; b_rx = 1'b0;
        s_rx = 1'b0; s_al = 1'b0;
        m_s[0] = 9'h1AA; m_s[1] = 9'h1AA;
        m_h[0] = '0; m_h[1] = '0;
        test_reset();
        test_lock_37();
        test_ber_count();
        test_loss_relock();
        test_enable_drop();
        test_async_reset();
        test_max_lat();
        test_lat_wrap();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
